// File: rtl/main_memory_responder.sv
// main_memory_responder
// ---------------------
// Backing store behind the cache controller. Single-word writes (write-through
// traffic) and whole-block reads (cache refills) each complete after a fixed,
// parameterised latency. Completion is a one-cycle 'ready' pulse. All state
// changes on the falling edge of clk so that it lines up with the cache
// controller's timing.
//
// Ports:
//   clk           clock, state changes on the falling edge
//   reset         synchronous, active-low
//   MemoryRead    block read request (sampled only in IDLE)
//   MemoryWrite   word write request (sampled only in IDLE, wins over read)
//   Word_Address  word address of the request
//   WriteData     data for a write request
//   ready         one-cycle completion pulse
//   ReadBlock     last refill block, word 0 in the LSBs; held until next read
//   busy          high while a transaction is in flight (incl. DONE cycle)
//
// The word array is split into WORDS_PER_BLOCK interleaved banks, one per
// word offset inside a block. A refill then reads one word from every bank
// in the same cycle, and each bank keeps a single read and single write port.

module main_memory_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  MemoryRead,
  input  logic                                  MemoryWrite,
  input  logic [ADDR_WIDTH-1:0]                 Word_Address,
  input  logic [DATA_WIDTH-1:0]                 WriteData,
  output logic                                  ready,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] ReadBlock,
  output logic                                  busy
);

  localparam int OFF_W      = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W      = ADDR_WIDTH - OFF_W;
  localparam int BANK_DEPTH = 2 ** IDX_W;
  localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        counter_q, counter_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    wr_commit;
  logic                    rd_commit;
  logic [IDX_W-1:0]        blk_idx;
  logic [ADDR_WIDTH-1:0]   word_off;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    addr_d    = addr_q;
    data_d    = data_q;
    unique case (state_q)
      IDLE: begin
        if (MemoryWrite) begin
          addr_d    = Word_Address;
          data_d    = WriteData;
          counter_d = CNT_W'(WRITE_LATENCY - 1);
          state_d   = BUSY_WR;
        end else if (MemoryRead) begin
          addr_d    = Word_Address;
          counter_d = CNT_W'(READ_LATENCY - 1);
          state_d   = BUSY_RD;
        end
      end
      BUSY_RD, BUSY_WR: begin
        if (counter_q == '0) begin
          state_d = DONE;
        end else begin
          counter_d = counter_q - CNT_W'(1);
        end
      end
      DONE: begin
        // Requests are deliberately not looked at here; a request still
        // held high is picked up on the following edge from IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);

  // The array access happens on the edge that enters DONE. Gating with reset
  // makes a reset on that same edge abort the transaction cleanly.
  assign wr_commit = reset && (state_q == BUSY_WR) && (counter_q == '0);
  assign rd_commit = reset && (state_q == BUSY_RD) && (counter_q == '0);

  // Row inside each bank and word offset inside the block.
  assign blk_idx  = IDX_W'(addr_q >> OFF_W);
  assign word_off = addr_q & ADDR_WIDTH'(WORDS_PER_BLOCK - 1);

  // ---------------------------------------------------------------------
  // Interleaved banks: bank gi holds every word whose offset is gi.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [0:BANK_DEPTH-1];
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  bank_we;

      assign bank_we = wr_commit && (word_off == ADDR_WIDTH'(gi));

      always_ff @(negedge clk) begin
        if (bank_we) begin
          mem[blk_idx] <= data_q;
        end
        // Output register doubles as this bank's slice of ReadBlock, so it
        // only moves on a refill and clears on reset.
        if (!reset) begin
          rd_q <= '0;
        end else if (rd_commit) begin
          rd_q <= mem[blk_idx];
        end
      end

      assign ReadBlock[gi*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int WPB = 4;
  localparam int RL  = 4;
  localparam int WL  = 4;
  localparam int BW  = DW * WPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemoryRead;
  logic          MemoryWrite;
  logic [AW-1:0] Word_Address;
  logic [DW-1:0] WriteData;
  logic          ready;
  logic [BW-1:0] ReadBlock;
  logic          busy;

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .WORDS_PER_BLOCK(WPB),
    .READ_LATENCY   (RL),
    .WRITE_LATENCY  (WL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemoryRead  (MemoryRead),
    .MemoryWrite (MemoryWrite),
    .Word_Address(Word_Address),
    .WriteData   (WriteData),
    .ready       (ready),
    .ReadBlock   (ReadBlock),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic          tog;   // toggle MemoryWrite at 0x020 while busy
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] exp;   // ReadBlock expected at the ready pulse
    logic [BW-1:0] mask;  // bits of ReadBlock with a known value
    string         name;
  } vec_t;

  typedef struct {
    logic [BW-1:0] exp;
    logic [BW-1:0] mask;
    string         name;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[13];

  function automatic vec_t mk(input logic wr, input logic rd, input logic tog,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [BW-1:0] exp, input logic [BW-1:0] mask,
                              input string name);
    vec_t v;
    v.wr = wr; v.rd = rd; v.tog = tog; v.addr = addr; v.data = data;
    v.exp = exp; v.mask = mask; v.name = name;
    return v;
  endfunction

  // One request accepted on the first falling edge E0; samples taken on the
  // rising edge after each falling edge E0+k.
  task automatic do_txn(input vec_t v);
    int  lat;
    int  ready_at;
    int  pulses;
    int  busy_drop;
    sb_t e;
    lat       = v.wr ? WL : RL;
    ready_at  = -1;
    pulses    = 0;
    busy_drop = -1;
    @(posedge clk);
    MemoryWrite  = v.wr;
    MemoryRead   = v.rd;
    Word_Address = v.addr;
    WriteData    = v.data;
    e.exp = v.exp; e.mask = v.mask; e.name = v.name;
    sb_q.push_back(e);
    for (int k = 0; k < lat + 3; k++) begin
      @(posedge clk);
      MemoryRead = 1'b0;
      if (v.tog && k <= lat) begin
        MemoryWrite  = (k % 2 == 0) || (k == lat);
        Word_Address = 10'h020;
        WriteData    = 32'hFFFF_FFFF;
      end else begin
        MemoryWrite = 1'b0;
      end
      if (ready) begin
        pulses++;
        if (ready_at < 0) ready_at = k;
        if (sb_q.size() == 0) begin
          chk({v.name, " spurious_ready"}, BW'(1), BW'(0));
        end else begin
          e = sb_q.pop_front();
          chk({e.name, " block"}, ReadBlock & e.mask, e.exp & e.mask);
        end
      end
      if (!busy && busy_drop < 0) busy_drop = k;
    end
    chk({v.name, " ready_latency"}, BW'(ready_at), BW'(lat));
    chk({v.name, " ready_pulses"}, BW'(pulses), BW'(1));
    chk({v.name, " busy_drop"}, BW'(busy_drop), BW'(lat + 1));
    if (sb_q.size() != 0) begin
      chk({v.name, " sb_drained"}, BW'(sb_q.size()), BW'(0));
      sb_q.delete();
    end
    $display("[TB] txn %-12s wr=%0d rd=%0d addr=%h data=%h ready_at=%0d pulses=%0d busy_drop=%0d block=%h",
             v.name, v.wr, v.rd, v.addr, v.data, ready_at, pulses, busy_drop, ReadBlock);
  endtask

  initial begin
    logic [BW-1:0] m_all;
    logic [BW-1:0] m0;
    logic [BW-1:0] m1;
    logic [BW-1:0] b1;
    logic [BW-1:0] br;
    logic [DW-1:0] pre_data [4];
    int            pulses;
    vec_t          v;

    m_all = '1;
    m0    = {96'h0, 32'hFFFF_FFFF};
    m1    = m0 << 32;
    b1    = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    br    = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    pre_data[0] = 32'h11; pre_data[1] = 32'h22; pre_data[2] = 32'h33; pre_data[3] = 32'h44;

    vecs[0] = mk(1'b1, 1'b0, 1'b0, 10'h005, 32'hDEAD_BEEF, '0, m_all, "wr_005");
    vecs[1] = mk(1'b0, 1'b1, 1'b0, 10'h006, 32'h0, b1, m1, "rd_006");
    for (int i = 0; i < 4; i++)
      vecs[2+i] = mk(1'b1, 1'b0, 1'b0, 10'(10'h3FC + i), pre_data[i], b1, m1,
                     $sformatf("wr_%h", 10'(10'h3FC + i)));
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 10'h3FE, 32'h0, br, m_all, "rd_3fe");
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 10'h010, 32'hA5A5_A5A5, br, m_all, "wr_rd_010");
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 10'h010, 32'h0, {96'h0, 32'hA5A5_A5A5}, m0, "rd_010");
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 10'h020, 32'h5555_5555, {96'h0, 32'hA5A5_A5A5}, m0, "wr_020");
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 10'h3FC, 32'h0, br, m_all, "rd_3fc_tog");
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 10'h020, 32'h0, {96'h0, 32'h5555_5555}, m0, "rd_020");
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 10'h030, 32'h0BAD_F00D, {96'h0, 32'h5555_5555}, m0, "wr_030");

    reset        = 1'b0;
    MemoryRead   = 1'b0;
    MemoryWrite  = 1'b0;
    Word_Address = '0;
    WriteData    = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    chk("reset ready", BW'(ready), BW'(0));
    chk("reset busy", BW'(busy), BW'(0));
    chk("reset ReadBlock", ReadBlock, '0);
    $display("[TB] txn reset        ready=%0d busy=%0d block=%h", ready, busy, ReadBlock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) do_txn(vecs[i]);

    // Reset during a write: accepted at E0, reset sampled low at E2.
    @(posedge clk);
    MemoryWrite  = 1'b1;
    Word_Address = 10'h030;
    WriteData    = 32'h1234_5678;
    @(posedge clk);
    MemoryWrite = 1'b0;
    chk("midrst busy_before", BW'(busy), BW'(1));
    @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    chk("midrst busy", BW'(busy), BW'(0));
    chk("midrst ReadBlock", ReadBlock, '0);
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (ready) pulses++;
    end
    chk("midrst ready_pulses", BW'(pulses), BW'(0));
    chk("midrst busy_after", BW'(busy), BW'(0));
    $display("[TB] txn midrst_030   ready_pulses=%0d busy=%0d block=%h", pulses, busy, ReadBlock);

    v = mk(1'b0, 1'b1, 1'b0, 10'h030, 32'h0, {96'h0, 32'h0BAD_F00D}, m0, "rd_030");
    do_txn(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
